// File: rtl/ipm_sync_wormhole.sv
// Switch input port: a DEPTH-entry flit FIFO feeding a wormhole router that locks one
// output port per packet and holds it until downstream reports that the tail has left.
module ipm_sync_wormhole #(
  parameter int WIDTH    = 32,
  parameter int OUTPORTS = 4,
  parameter int DEPTH    = 4,
  parameter int DEST_LSB = 0,
  parameter int DEST_W   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid_i,
  input  logic [WIDTH-1:0]          in_data_i,
  output logic                      in_ready_o,
  output logic [OUTPORTS-1:0]       out_valid_o,
  output logic [OUTPORTS*WIDTH-1:0] out_data_o,
  input  logic [OUTPORTS-1:0]       out_ready_i,
  input  logic [OUTPORTS-1:0]       tailpassed_i,
  output logic [OUTPORTS-1:0]       packet_enable_o,
  output logic                      route_err_o,
  output logic [$clog2(DEPTH):0]    fifo_count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(OUTPORTS);

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOCK,
    ST_WAIT_TAIL,
    ST_DROP
  } state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_next;
  logic             in_ready_q;

  state_t           state_q;
  logic [IDX_W-1:0] dest_q;
  logic             first_q;
  logic             route_err_q;

  logic [WIDTH-1:0]    head;
  flit_type_t          head_type;
  logic [DEST_W-1:0]   dest_raw;
  logic                dest_ok, is_head, empty;
  logic                push, pop, lock_pop, idle_drop, drop_pop, ends_packet;
  logic [OUTPORTS-1:0] dest_onehot;

  assign empty     = (count_q == '0);
  assign head      = mem[rd_ptr_q];
  assign head_type = flit_type_t'(head[WIDTH-1 -: 2]);
  assign dest_raw  = head[DEST_LSB +: DEST_W];
  assign dest_ok   = (int'(dest_raw) < OUTPORTS);
  assign is_head   = (head_type == FT_HEAD) || (head_type == FT_SINGLE);

  // A SINGLE only closes the packet when it is the flit that opened it; later ones ride as BODY.
  assign ends_packet = (head_type == FT_TAIL) || ((head_type == FT_SINGLE) && first_q);

  assign push      = in_valid_i && in_ready_q;
  assign lock_pop  = (state_q == ST_LOCK) && !empty && out_ready_i[dest_q];
  assign idle_drop = (state_q == ST_IDLE) && !empty && !(is_head && dest_ok);
  assign drop_pop  = (state_q == ST_DROP) && !empty;
  assign pop       = lock_pop || idle_drop || drop_pop;

  assign count_next = count_q + CNT_W'(push) - CNT_W'(pop);

  // NOTE: flit storage carries no reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data_i;
  end

  // in_ready is registered from the next count so it reads 0 while reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_next;
      in_ready_q <= (count_next != CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      dest_q      <= '0;
      first_q     <= 1'b0;
      route_err_q <= 1'b0;
    end else begin
      route_err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!empty) begin
            if (is_head && dest_ok) begin
              dest_q  <= IDX_W'(dest_raw);
              first_q <= 1'b1;
              state_q <= ST_LOCK;
            end else begin
              route_err_q <= 1'b1;
              if (head_type == FT_HEAD) state_q <= ST_DROP;
            end
          end
        end
        ST_LOCK: begin
          if (lock_pop) begin
            first_q <= 1'b0;
            if (ends_packet) state_q <= tailpassed_i[dest_q] ? ST_IDLE : ST_WAIT_TAIL;
          end
        end
        ST_WAIT_TAIL: begin
          if (tailpassed_i[dest_q]) state_q <= ST_IDLE;
        end
        ST_DROP: begin
          if (drop_pop && (head_type == FT_TAIL)) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dest_onehot     = OUTPORTS'(1) << dest_q;
  assign packet_enable_o = ((state_q == ST_LOCK) || (state_q == ST_WAIT_TAIL)) ? dest_onehot : '0;
  assign out_valid_o     = ((state_q == ST_LOCK) && !empty) ? dest_onehot : '0;
  assign out_data_o      = {OUTPORTS{head}};
  assign in_ready_o      = in_ready_q;
  assign route_err_o     = route_err_q;
  assign fifo_count_o    = count_q;

endmodule

// File: tb/tb_ipm_sync_wormhole.sv
// Bench for ipm_sync_wormhole: directed timing checks plus randomized traffic scored
// against a packet-level model of which flits must reach which port.
module tb_ipm_sync_wormhole;

  localparam int WIDTH    = 32;
  localparam int OUTPORTS = 4;
  localparam int DEPTH    = 4;
  localparam int DEST_LSB = 0;
  localparam int DEST_W   = 3;

  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  typedef struct {
    int               port;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      reset = 1'b0;
  logic                      in_valid_i = 1'b0;
  logic [WIDTH-1:0]          in_data_i = '0;
  logic                      in_ready_o;
  logic [OUTPORTS-1:0]       out_valid_o;
  logic [OUTPORTS*WIDTH-1:0] out_data_o;
  logic [OUTPORTS-1:0]       out_ready_i = '0;
  logic [OUTPORTS-1:0]       tailpassed_i = '0;
  logic [OUTPORTS-1:0]       packet_enable_o;
  logic                      route_err_o;
  logic [$clog2(DEPTH):0]    fifo_count_o;

  ipm_sync_wormhole #(
    .WIDTH(WIDTH), .OUTPORTS(OUTPORTS), .DEPTH(DEPTH), .DEST_LSB(DEST_LSB), .DEST_W(DEST_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid_i(in_valid_i),
    .in_data_i(in_data_i),
    .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o),
    .out_data_o(out_data_o),
    .out_ready_i(out_ready_i),
    .tailpassed_i(tailpassed_i),
    .packet_enable_o(packet_enable_o),
    .route_err_o(route_err_o),
    .fifo_count_o(fifo_count_o)
  );

  always #5 clk = ~clk;

  int  n_tests  = 0;
  int  n_fail   = 0;
  int  n_out    = 0;
  int  seen_err = 0;
  int  exp_err  = 0;
  int  m_port   = -1;
  bit  m_drop   = 1'b0;
  bit  mon_on   = 1'b0;

  logic [WIDTH-1:0] src_q [$];
  exp_t             exp_q [$];
  exp_t             mon_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [WIDTH-1:0] mk(input logic [1:0] t, input int d);
    logic [WIDTH-1:0] f;
    f = $urandom;
    f[WIDTH-1 -: 2] = t;
    f[DEST_LSB +: DEST_W] = DEST_W'(d);
    return f;
  endfunction

  // Packet-level reference: what each accepted flit must turn into, in arrival order.
  function automatic void model_push(input logic [WIDTH-1:0] f);
    logic [1:0] t;
    int         d;
    exp_t       e;
    t = f[WIDTH-1 -: 2];
    d = int'(f[DEST_LSB +: DEST_W]);
    if (m_drop) begin
      if (t == FT_TAIL) m_drop = 1'b0;
    end else if (m_port >= 0) begin
      e.port = m_port; e.data = f; exp_q.push_back(e);
      if (t == FT_TAIL) m_port = -1;
    end else if (t == FT_HEAD || t == FT_SINGLE) begin
      if (d < OUTPORTS) begin
        e.port = d; e.data = f; exp_q.push_back(e);
        if (t == FT_HEAD) m_port = d;
      end else begin
        exp_err++;
        if (t == FT_HEAD) m_drop = 1'b1;
      end
    end else begin
      exp_err++;
    end
  endfunction

  function automatic void model_clear();
    src_q.delete();
    exp_q.delete();
    m_port   = -1;
    m_drop   = 1'b0;
    exp_err  = 0;
    seen_err = 0;
  endfunction

  // Inputs change 1 time unit after the rising edge, so at the falling edge they
  // already hold the values the next rising edge will act on.
  always @(negedge clk) begin
    if (reset && mon_on) begin
      if (in_valid_i && in_ready_o) model_push(in_data_i);
      if (route_err_o) seen_err++;
      check("in_ready_vs_count", in_ready_o, fifo_count_o < DEPTH);
      check("pkt_en_onehot0", $onehot0(packet_enable_o), 1);
      if (out_valid_o != '0) begin
        check("valid_onehot", $onehot(out_valid_o), 1);
        check("valid_within_pkt_en", out_valid_o & ~packet_enable_o, 0);
      end
      for (int k = 0; k < OUTPORTS; k++) begin
        if (out_valid_o[k] && out_ready_i[k]) begin
          n_out++;
          check("out_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("out_port", k, mon_e.port);
            check("out_data", out_data_o[k*WIDTH +: WIDTH], mon_e.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_on = 1'b0;
    in_valid_i = 1'b0; out_ready_i = '0; tailpassed_i = '0;
    reset = 1'b0;
    #1;
    model_clear();
    check("rst_out_valid", out_valid_o, 0);
    check("rst_pkt_en", packet_enable_o, 0);
    check("rst_route_err", route_err_o, 0);
    check("rst_in_ready", in_ready_o, 0);
    check("rst_count", fifo_count_o, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    tick();
    mon_on = 1'b1;
  endtask

  // One cycle of traffic from src_q; random mode randomizes gaps, readies and tail reports.
  task automatic run(input int cycles, input bit rnd, input logic [OUTPORTS-1:0] rdy);
    for (int c = 0; c < cycles; c++) begin
      if (src_q.size() != 0 && (!rnd || $urandom_range(3) != 0)) begin
        in_valid_i = 1'b1;
        in_data_i  = src_q[0];
        if (in_ready_o) void'(src_q.pop_front());
      end else begin
        in_valid_i = 1'b0;
      end
      out_ready_i  = rnd ? (OUTPORTS'($urandom) | OUTPORTS'($urandom)) : rdy;
      tailpassed_i = rnd ? (OUTPORTS'($urandom) & OUTPORTS'($urandom) & OUTPORTS'($urandom)) : '1;
      tick();
    end
    in_valid_i = 1'b0;
    tailpassed_i = '0;
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0 || fifo_count_o != 0) && c < 5000) begin
      run(1, 1'b0, '1);
      c++;
    end
    run(3, 1'b0, '1);
    check({tag, "_drain_in_time"}, c < 5000, 1);
    check({tag, "_all_delivered"}, exp_q.size() + src_q.size(), 0);
    check({tag, "_route_err_count"}, seen_err, exp_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d comparisons so far", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] f [5];
    logic [WIDTH-1:0] s;
    int n0, e0;

    do_reset();
    check("post_rst_in_ready", in_ready_o, 1);

    // SINGLE to port 2: lock at t0+2, then wait for the port-2 tail report only.
    s = mk(FT_SINGLE, 2);
    out_ready_i = '1; tailpassed_i = '0;
    in_valid_i = 1'b1; in_data_i = s;
    tick();
    in_valid_i = 1'b0;
    check("single_count_t1", fifo_count_o, 1);
    check("single_valid_t1", out_valid_o, 0);
    tick();
    check("single_valid_t2", out_valid_o, 4'b0100);
    check("single_pkt_en_t2", packet_enable_o, 4'b0100);
    check("single_data_t2", out_data_o[2*WIDTH +: WIDTH], s);
    tick();
    check("single_wait_valid", out_valid_o, 0);
    check("single_wait_pkt_en", packet_enable_o, 4'b0100);
    check("single_wait_count", fifo_count_o, 0);
    tailpassed_i = 4'b1011;
    tick();
    tailpassed_i = '0;
    check("single_other_tp_ignored", packet_enable_o, 4'b0100);
    tick();
    tailpassed_i = 4'b0100;
    tick();
    tailpassed_i = '0;
    check("single_released", packet_enable_o, 0);

    // Back-to-back 5-flit packet on port 1: one flit per cycle; the HEAD waits one
    // cycle for its routing decision, so two flits sit in the FIFO while streaming.
    f[0] = mk(FT_HEAD, 1);
    for (int i = 1; i < 4; i++) f[i] = mk(FT_BODY, i);
    f[4] = mk(FT_TAIL, 0);
    for (int i = 0; i < 5; i++) src_q.push_back(f[i]);
    n0 = n_out;
    for (int j = 0; j < 7; j++) begin
      check("b2b_in_ready", in_ready_o, 1);
      run(1, 1'b0, 4'b0010);
      if (j >= 1 && j <= 5) begin
        check("b2b_valid", out_valid_o, 4'b0010);
        check("b2b_data", out_data_o[1*WIDTH +: WIDTH], f[j-1]);
      end
      check("b2b_count_le2", fifo_count_o <= 2, 1);
    end
    check("b2b_delivered", n_out - n0, 5);
    drain("b2b");

    // Tail popped with tailpassed in the same cycle goes straight to IDLE.
    out_ready_i = '1; tailpassed_i = '0;
    in_valid_i = 1'b1; in_data_i = mk(FT_SINGLE, 0);
    tick();
    in_data_i = mk(FT_HEAD, 1);
    tick();
    in_valid_i = 1'b0;
    check("tp_lock0", out_valid_o, 4'b0001);
    tailpassed_i = 4'b0001;
    tick();
    tailpassed_i = '0;
    check("tp_idle_direct", packet_enable_o, 0);
    tick();
    check("tp_next_lock_en", packet_enable_o, 4'b0010);
    check("tp_next_lock_valid", out_valid_o, 4'b0010);
    src_q.push_back(mk(FT_TAIL, 0));
    drain("tp");

    // Backpressure: four flits fill the FIFO, the fifth is held upstream.
    src_q.push_back(mk(FT_HEAD, 3));
    for (int i = 0; i < 3; i++) src_q.push_back(mk(FT_BODY, i));
    src_q.push_back(mk(FT_TAIL, 7));
    n0 = n_out;
    run(8, 1'b0, '0);
    check("bp_fifth_held", src_q.size(), 1);
    check("bp_count_full", fifo_count_o, 4);
    check("bp_in_ready_low", in_ready_o, 0);
    drain("bp");
    check("bp_delivered", n_out - n0, 5);

    // Bad destination: the whole packet is dropped with one error, then traffic resumes.
    src_q.push_back(mk(FT_HEAD, 5));
    src_q.push_back(mk(FT_BODY, 1));
    src_q.push_back(mk(FT_TAIL, 2));
    src_q.push_back(mk(FT_SINGLE, 0));
    e0 = seen_err;
    n0 = n_out;
    for (int j = 0; j < 4; j++) begin
      run(1, 1'b0, '1);
      check("bad_no_valid", out_valid_o, 0);
    end
    drain("bad");
    check("bad_err_once", seen_err - e0, 1);
    check("bad_then_single", n_out - n0, 1);

    // Orphan BODY in IDLE: one-cycle error pulse, flit discarded.
    in_valid_i = 1'b1; in_data_i = mk(FT_BODY, 0);
    tick();
    in_valid_i = 1'b0;
    check("orphan_count", fifo_count_o, 1);
    check("orphan_err_early", route_err_o, 0);
    tick();
    check("orphan_err", route_err_o, 1);
    check("orphan_dropped", fifo_count_o, 0);
    tick();
    check("orphan_err_pulse", route_err_o, 0);
    drain("orphan");

    // Reset in the middle of a locked packet.
    out_ready_i = '0;
    in_valid_i = 1'b1; in_data_i = mk(FT_HEAD, 2);
    tick();
    in_data_i = mk(FT_BODY, 0);
    tick();
    in_valid_i = 1'b0;
    tick();
    check("mid_rst_locked", packet_enable_o, 4'b0100);
    check("mid_rst_count", fifo_count_o, 2);
    #2 mon_on = 1'b0;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", out_valid_o, 0);
    check("mid_rst_pkt_en", packet_enable_o, 0);
    check("mid_rst_count0", fifo_count_o, 0);
    check("mid_rst_in_ready", in_ready_o, 0);
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    out_ready_i = '1;
    for (int j = 0; j < 4; j++) tick();
    mon_on = 1'b1;
    check("post_mid_rst_pkt_en", packet_enable_o, 0);
    check("post_mid_rst_valid", out_valid_o, 0);
    check("post_mid_rst_count", fifo_count_o, 0);
    check("post_mid_rst_in_ready", in_ready_o, 1);
    src_q.push_back(mk(FT_SINGLE, 1));
    n0 = n_out;
    drain("post_rst");
    check("post_rst_delivered", n_out - n0, 1);

    // Randomized packet mix: good/bad heads, singles, orphans, stray mid-packet heads.
    for (int p = 0; p < 200; p++) begin
      int kind, d, nb;
      kind = $urandom_range(9);
      d    = $urandom_range(3);
      if (kind <= 5) begin
        if (kind == 5) d = $urandom_range(7, 4);
        src_q.push_back(mk(FT_HEAD, d));
        nb = $urandom_range(3);
        for (int b = 0; b < nb; b++) begin
          if ($urandom_range(9) == 0)
            src_q.push_back(mk(($urandom_range(1) != 0) ? FT_HEAD : FT_SINGLE, $urandom_range(7)));
          else
            src_q.push_back(mk(FT_BODY, $urandom_range(7)));
        end
        src_q.push_back(mk(FT_TAIL, $urandom_range(7)));
      end else if (kind <= 7) begin
        if (kind == 7) d = $urandom_range(7, 4);
        src_q.push_back(mk(FT_SINGLE, d));
      end else begin
        src_q.push_back(mk(($urandom_range(1) != 0) ? FT_BODY : FT_TAIL, $urandom_range(7)));
      end
    end
    run(3000, 1'b1, '0);
    drain("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
